// File: rtl/debug_io_pkg.sv
// Shared definitions for the debug pin scheduler: source group codes,
// mode encodings and the scheduler state type.
package debug_io_pkg;

  localparam int NUM_PINS = 4;

  localparam logic [1:0] GRP_FSYNC  = 2'd0;
  localparam logic [1:0] GRP_FILTER = 2'd1;
  localparam logic [1:0] GRP_VS     = 2'd2;
  localparam logic [1:0] GRP_AUX    = 2'd3;

  localparam logic MODE_STATIC = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STATIC = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

endpackage

// File: rtl/debug_pulse_stretch.sv
// Per-pin pulse stretcher: a rising edge of sel keeps the pin high for
// 'stretch' extra cycles; clear drops any running stretch and re-seeds the
// edge history from the current sel so no false edge is seen afterwards.
module debug_pulse_stretch #(
  parameter int STR_W = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             sel,
  input  logic             clear,
  input  logic [STR_W-1:0] stretch,
  output logic             pin
);

  logic             sel_prev_reg;
  logic [STR_W-1:0] cnt_reg;
  logic [STR_W-1:0] cnt_next;
  logic             out_reg;
  logic             rise;

  // Edge detect and counter reload/decrement.
  always_comb begin
    rise     = sel & ~sel_prev_reg;
    cnt_next = '0;
    if (rise) begin
      cnt_next = stretch;
    end else if (cnt_reg != '0) begin
      cnt_next = cnt_reg - STR_W'(1);
    end
  end

  // Registered output: the live level ORed with any stretch still pending.
  always_ff @(posedge clk) begin
    if (srst) begin
      sel_prev_reg <= 1'b0;
      cnt_reg      <= '0;
      out_reg      <= 1'b0;
    end else if (clear) begin
      sel_prev_reg <= sel;
      cnt_reg      <= '0;
      out_reg      <= sel;
    end else begin
      sel_prev_reg <= sel;
      cnt_reg      <= cnt_next;
      out_reg      <= sel | (cnt_reg != '0);
    end
  end

  assign pin = out_reg;

endmodule

// File: rtl/debug_io_scheduler.sv
// Routes the four debug source groups onto four debug header pins, either
// statically (one group/bit per pin) or by scanning every bit index across
// all groups, with per-pin pulse stretching for scope visibility.
module debug_io_scheduler
  import debug_io_pkg::*;
#(
  parameter int  NBIT    = 8,
  parameter int  DWELL_W = 16,
  parameter int  STR_W   = 8,
  localparam int IDX_W   = $clog2(NBIT)
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESET,
  input  logic [NBIT-1:0]          FSYNC_I,
  input  logic [NBIT-1:0]          FSYNC_FILTER_I,
  input  logic [NBIT-1:0]          VS_I,
  input  logic [NBIT-1:0]          AUX_I,
  input  logic                     CFG_EN_I,
  input  logic                     CFG_MODE_I,
  input  logic [4*(2+IDX_W)-1:0]   CFG_SEL_I,
  input  logic [DWELL_W-1:0]       CFG_DWELL_I,
  input  logic [STR_W-1:0]         CFG_STRETCH_I,
  input  logic                     CFG_UPDATE_I,
  output logic [3:0]               DEBUG_O,
  output logic [IDX_W-1:0]         SCAN_IDX_O,
  output logic                     SCAN_WRAP_O,
  output logic                     CFG_ERR_O
);

  localparam int FW = 2 + IDX_W;

  logic [NUM_PINS-1:0][NBIT-1:0] src_reg;
  logic [4*FW-1:0]               cfg_sel_reg;
  logic [DWELL_W-1:0]            cfg_dwell_reg;
  logic [STR_W-1:0]              cfg_stretch_reg;
  logic [DWELL_W-1:0]            dwell_cnt_reg;
  logic [DWELL_W-1:0]            dwell_last;
  logic [IDX_W-1:0]              scan_idx_reg;
  logic                          wrap_reg;
  logic                          err_reg;
  logic                          upd_dly_reg;
  logic                          idx_step_reg;
  logic                          dwell_term;
  logic                          stretch_clear;
  logic [NUM_PINS-1:0]           idx_bad;
  state_t                        state_reg;
  state_t                        state_next;

  // Stage 1: capture all source groups.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      src_reg <= '0;
    end else begin
      src_reg[GRP_FSYNC]  <= FSYNC_I;
      src_reg[GRP_FILTER] <= FSYNC_FILTER_I;
      src_reg[GRP_VS]     <= VS_I;
      src_reg[GRP_AUX]    <= AUX_I;
    end
  end

  // Next state: only a config update moves the scheduler between modes.
  always_comb begin
    state_next = state_reg;
    if (CFG_UPDATE_I) begin
      if (!CFG_EN_I) begin
        state_next = ST_IDLE;
      end else if (CFG_MODE_I == MODE_SCAN) begin
        state_next = ST_SCAN;
      end else begin
        state_next = ST_STATIC;
      end
    end
  end

  // State register.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A dwell of 0 behaves as 1, so the last count is then 0 as well.
  assign dwell_last = (cfg_dwell_reg == '0) ? '0 : cfg_dwell_reg - DWELL_W'(1);
  assign dwell_term = (state_reg == ST_SCAN) && (dwell_cnt_reg == dwell_last);

  // Stretchers are re-seeded one cycle after an update or index step, i.e.
  // on the first edge where sel already reflects the new selection.
  assign stretch_clear = upd_dly_reg | idx_step_reg;

  // Active config, scan sequencing and config error flag; update beats dwell.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      cfg_sel_reg     <= '0;
      cfg_dwell_reg   <= '0;
      cfg_stretch_reg <= '0;
      dwell_cnt_reg   <= '0;
      scan_idx_reg    <= '0;
      wrap_reg        <= 1'b0;
      err_reg         <= 1'b0;
      upd_dly_reg     <= 1'b0;
      idx_step_reg    <= 1'b0;
    end else if (CFG_UPDATE_I) begin
      cfg_sel_reg     <= CFG_SEL_I;
      cfg_dwell_reg   <= CFG_DWELL_I;
      cfg_stretch_reg <= CFG_STRETCH_I;
      dwell_cnt_reg   <= '0;
      scan_idx_reg    <= '0;
      wrap_reg        <= 1'b0;
      err_reg         <= CFG_EN_I && (CFG_MODE_I == MODE_STATIC) && (|idx_bad);
      upd_dly_reg     <= 1'b1;
      idx_step_reg    <= 1'b0;
    end else begin
      upd_dly_reg  <= 1'b0;
      idx_step_reg <= 1'b0;
      wrap_reg     <= 1'b0;
      if (state_reg == ST_SCAN) begin
        if (dwell_term) begin
          dwell_cnt_reg <= '0;
          idx_step_reg  <= 1'b1;
          if (scan_idx_reg == IDX_W'(NBIT - 1)) begin
            scan_idx_reg <= '0;
            wrap_reg     <= 1'b1;
          end else begin
            scan_idx_reg <= scan_idx_reg + IDX_W'(1);
          end
        end else begin
          dwell_cnt_reg <= dwell_cnt_reg + DWELL_W'(1);
        end
      end
    end
  end

  // Stage 2: per-pin selection feeding a pulse stretcher.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PINS; gi++) begin : g_pin
      logic [1:0]       grp;
      logic [IDX_W-1:0] idx;
      logic             pin_sel;

      assign grp         = cfg_sel_reg[gi*FW+IDX_W +: 2];
      assign idx         = cfg_sel_reg[gi*FW +: IDX_W];
      assign idx_bad[gi] = int'(CFG_SEL_I[gi*FW +: IDX_W]) >= NBIT;

      // Pick this pin's source bit for the current mode; bad idx reads 0.
      always_comb begin
        pin_sel = 1'b0;
        case (state_reg)
          ST_STATIC: if (int'(idx) < NBIT) pin_sel = src_reg[grp][idx];
          ST_SCAN:   pin_sel = src_reg[gi][scan_idx_reg];
          default:   pin_sel = 1'b0;
        endcase
      end

      debug_pulse_stretch #(.STR_W(STR_W)) u_stretch (
        .clk     (S_AXI_ACLK),
        .srst    (S_AXI_ARESET),
        .sel     (pin_sel),
        .clear   (stretch_clear),
        .stretch (cfg_stretch_reg),
        .pin     (DEBUG_O[gi])
      );
    end
  endgenerate

  assign SCAN_IDX_O  = scan_idx_reg;
  assign SCAN_WRAP_O = wrap_reg;
  assign CFG_ERR_O   = err_reg;

endmodule

// File: tb/tb_debug_io_scheduler.sv
// Scoreboard bench: the stimulus process advances a behavioural model and
// queues the expected outputs of two instances (NBIT=8 and NBIT=6); a
// monitor pops and compares them once per cycle.
module tb_debug_io_scheduler;

  localparam int DW = 16;
  localparam int SW = 8;
  localparam int FW = 5;

  typedef struct packed {
    logic [3:0] debug;
    logic [2:0] idx;
    logic       wrap;
    logic       err;
  } exp_t;

  typedef struct packed {
    exp_t e1;
    exp_t e0;
  } pair_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            srst, cfg_en, cfg_mode, cfg_update;
  logic [4*FW-1:0] cfg_sel;
  logic [DW-1:0]   cfg_dwell;
  logic [SW-1:0]   cfg_stretch;
  logic [3:0][7:0] src;
  logic [3:0]      dbg8, dbg6;
  logic [2:0]      idx8, idx6;
  logic            wrap8, wrap6, err8, err6;

  debug_io_scheduler #(.NBIT(8), .DWELL_W(DW), .STR_W(SW)) dut8 (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(srst),
    .FSYNC_I(src[0]), .FSYNC_FILTER_I(src[1]), .VS_I(src[2]), .AUX_I(src[3]),
    .CFG_EN_I(cfg_en), .CFG_MODE_I(cfg_mode), .CFG_SEL_I(cfg_sel),
    .CFG_DWELL_I(cfg_dwell), .CFG_STRETCH_I(cfg_stretch), .CFG_UPDATE_I(cfg_update),
    .DEBUG_O(dbg8), .SCAN_IDX_O(idx8), .SCAN_WRAP_O(wrap8), .CFG_ERR_O(err8)
  );

  debug_io_scheduler #(.NBIT(6), .DWELL_W(DW), .STR_W(SW)) dut6 (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(srst),
    .FSYNC_I(src[0][5:0]), .FSYNC_FILTER_I(src[1][5:0]), .VS_I(src[2][5:0]), .AUX_I(src[3][5:0]),
    .CFG_EN_I(cfg_en), .CFG_MODE_I(cfg_mode), .CFG_SEL_I(cfg_sel),
    .CFG_DWELL_I(cfg_dwell), .CFG_STRETCH_I(cfg_stretch), .CFG_UPDATE_I(cfg_update),
    .DEBUG_O(dbg6), .SCAN_IDX_O(idx6), .SCAN_WRAP_O(wrap6), .CFG_ERR_O(err6)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  int    edge_no  = 0;
  bit    started  = 0;
  pair_t exp_q[$];

  // Reference model state, one slot per instance.
  bit              m_en[2], m_mode[2], m_pend[2], m_err[2];
  logic [4*FW-1:0] m_sel[2];
  int              m_dwell[2], m_stretch[2], m_elapsed[2];
  logic [3:0][7:0] m_src[2];
  bit              m_prev[2][4], m_rv[2][4];
  int              m_rise_at[2][4], m_rise_s[2][4];

  function automatic logic [4:0] fld(int g, int i);
    logic [1:0] gg;
    logic [2:0] ii;
    gg = 2'(g);
    ii = 3'(i);
    return {gg, ii};
  endfunction

  // Outputs after the upcoming edge, from the scheduling rules.
  task automatic model_edge(input int ii, output exp_t e);
    int nb, d, grp, bi;
    bit s, scan, bad;
    nb = (ii == 0) ? 8 : 6;
    e  = '0;
    if (srst) begin
      m_en[ii] = 0; m_mode[ii] = 0; m_sel[ii] = '0; m_dwell[ii] = 0; m_stretch[ii] = 0;
      m_src[ii] = '0; m_elapsed[ii] = 0; m_pend[ii] = 0; m_err[ii] = 0;
      for (int p = 0; p < 4; p++) begin
        m_prev[ii][p] = 0;
        m_rv[ii][p]   = 0;
      end
    end else begin
      d = (m_dwell[ii] == 0) ? 1 : m_dwell[ii];
      for (int p = 0; p < 4; p++) begin
        s = 0;
        if (m_en[ii] && !m_mode[ii]) begin
          grp = int'(m_sel[ii][p*FW+3 +: 2]);
          bi  = int'(m_sel[ii][p*FW +: 3]);
          if (bi < nb) s = m_src[ii][grp][bi];
        end else if (m_en[ii]) begin
          s = m_src[ii][p][(m_elapsed[ii] / d) % nb];
        end
        if (m_pend[ii]) begin
          m_rv[ii][p] = 0;
        end else if (s && !m_prev[ii][p]) begin
          m_rv[ii][p]      = 1;
          m_rise_at[ii][p] = edge_no;
          m_rise_s[ii][p]  = m_stretch[ii];
        end
        e.debug[p] = s || (m_rv[ii][p] && (edge_no - m_rise_at[ii][p] >= 1)
                           && (edge_no - m_rise_at[ii][p] <= m_rise_s[ii][p]));
        m_prev[ii][p] = s;
      end
      if (cfg_update) begin
        bad = 0;
        for (int p = 0; p < 4; p++) if (int'(cfg_sel[p*FW +: 3]) >= nb) bad = 1;
        m_en[ii] = cfg_en; m_mode[ii] = cfg_mode; m_sel[ii] = cfg_sel;
        m_dwell[ii] = int'(cfg_dwell); m_stretch[ii] = int'(cfg_stretch);
        m_elapsed[ii] = 0; m_pend[ii] = 1;
        m_err[ii] = cfg_en && !cfg_mode && bad;
      end else begin
        m_pend[ii] = 0;
        if (m_en[ii] && m_mode[ii]) begin
          m_elapsed[ii]++;
          if (m_elapsed[ii] % d == 0) m_pend[ii] = 1;
        end
      end
      scan   = m_en[ii] && m_mode[ii];
      e.idx  = scan ? 3'((m_elapsed[ii] / d) % nb) : 3'd0;
      e.wrap = scan && !cfg_update && (m_elapsed[ii] % (d * nb) == 0);
      e.err  = m_err[ii];
      m_src[ii] = src;
    end
  endtask

  // Queue expectations for the next edge, then let that edge happen.
  task automatic tick();
    pair_t pr;
    exp_t  a, b;
    edge_no++;
    model_edge(0, a);
    model_edge(1, b);
    pr.e0 = a;
    pr.e1 = b;
    exp_q.push_back(pr);
    started = 1;
    @(posedge clk);
    #1;
    cfg_update = 1'b0;
  endtask

  task automatic upd(input bit en, input bit mode, input logic [4*FW-1:0] sel,
                     input int dwell, input int stretch);
    cfg_en = en; cfg_mode = mode; cfg_sel = sel;
    cfg_dwell = DW'(dwell); cfg_stretch = SW'(stretch); cfg_update = 1'b1;
    $display("cfg update @%0t: en=%0d mode=%0d sel=%h dwell=%0d stretch=%0d",
             $time, en, mode, sel, dwell, stretch);
    tick();
    // Scramble the config inputs: they must be ignored until the next strobe.
    cfg_en = 1'($urandom); cfg_mode = 1'($urandom); cfg_sel = 20'($urandom);
    cfg_dwell = DW'($urandom); cfg_stretch = SW'($urandom);
  endtask

  task automatic cmp(input string nm, input logic [3:0] got, input logic [3:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, got, want);
    end
  endtask

  // Monitor: one set of comparisons per cycle, away from the active edge.
  initial begin
    pair_t pr;
    wait (started);
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        pr = exp_q.pop_front();
        cmp("debug8", dbg8, pr.e0.debug);
        cmp("idx8", {1'b0, idx8}, {1'b0, pr.e0.idx});
        cmp("wrap8", {3'b0, wrap8}, {3'b0, pr.e0.wrap});
        cmp("err8", {3'b0, err8}, {3'b0, pr.e0.err});
        cmp("debug6", dbg6, pr.e1.debug);
        cmp("idx6", {1'b0, idx6}, {1'b0, pr.e1.idx});
        cmp("wrap6", {3'b0, wrap6}, {3'b0, pr.e1.wrap});
        cmp("err6", {3'b0, err6}, {3'b0, pr.e1.err});
      end
    end
  end

  // Stimulus.
  initial begin
    logic [4*FW-1:0] sel_id;
    srst = 1'b1; cfg_en = 1'b0; cfg_mode = 1'b0; cfg_update = 1'b0;
    cfg_sel = '0; cfg_dwell = '0; cfg_stretch = '0;
    src = {4{8'hFF}};
    sel_id = {fld(3, 0), fld(2, 0), fld(1, 0), fld(0, 0)};
    @(posedge clk);
    #1;

    // Reset held with sources high, then idle without any update.
    repeat (5) tick();
    srst = 1'b0;
    repeat (4) tick();

    // Static routing of bit 0 of each group, no stretch.
    upd(1, 0, sel_id, 0, 0);
    src = '0;
    tick();
    src[0][0] = 1'b1; src[1][0] = 1'b0; src[2][0] = 1'b1; src[3][0] = 1'b1;
    repeat (4) tick();

    // Stretch of 3: single pulse, then two pulses two cycles apart.
    upd(1, 0, sel_id, 0, 3);
    src = '0;
    repeat (3) tick();
    src[2][0] = 1'b1; tick(); src[2][0] = 1'b0;
    repeat (7) tick();
    src[2][0] = 1'b1; tick(); src[2][0] = 1'b0; tick();
    src[2][0] = 1'b1; tick(); src[2][0] = 1'b0;
    repeat (9) tick();

    // Scan, dwell 4, two full sweeps; the next update lands on the idx-7 terminal.
    src = {4{8'h05}};
    upd(1, 1, '0, 4, 0);
    repeat (63) tick();
    upd(1, 1, '0, 2, 0);
    repeat (7) tick();
    upd(0, 0, '0, 2, 0);
    repeat (3) tick();

    // Out-of-range index on pin 1 (only out of range for NBIT=6), then fixed.
    upd(1, 0, {fld(3, 1), fld(2, 2), fld(1, 7), fld(0, 3)}, 0, 0);
    repeat (6) begin
      src = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      tick();
    end
    upd(1, 0, {fld(3, 1), fld(2, 2), fld(1, 5), fld(0, 3)}, 0, 0);
    repeat (4) tick();

    // Randomized scenarios with sparse source toggles, stray updates and resets.
    for (int sc = 0; sc < 40; sc++) begin
      int len;
      len = $urandom_range(10, 60);
      upd($urandom_range(0, 7) != 0, 1'($urandom), 20'($urandom),
          $urandom_range(0, 5), $urandom_range(0, 4));
      for (int c = 0; c < len; c++) begin
        for (int g = 0; g < 4; g++)
          src[g] = src[g] ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
        if ($urandom_range(0, 99) == 0) begin
          srst = 1'b1;
          cfg_update = 1'($urandom);
          tick();
          srst = 1'b0;
        end else if ($urandom_range(0, 49) == 0) begin
          upd(1, 1'($urandom), 20'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
        end else begin
          tick();
        end
      end
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_io_scheduler.md
Name: debug_io_scheduler

Overview:
Selects and schedules which of the four 8-bit debug source groups (FSYNC, FSYNC_FILTER, VS, AUX) drive the four physical debug pins. It supports two modes. Static mode routes one group/bit to each pin. Scan mode time-multiplexes every bit index across all four pins. Pulse stretching makes single-cycle events visible on a scope. It sits between the video-timing debug taps and the board debug header, and is configured by the AXI-Lite register block in the same S_AXI_ACLK domain.

Parameters:
NBIT, 8, bits per source group; IDX_W = clog2(NBIT)
DWELL_W, 16, width of scan dwell count
STR_W, 8, width of stretch count

Ports:
S_AXI_ACLK  in  1  bus clock; the only clock
S_AXI_ARESET  in  1  reset, synchronous, active-high
FSYNC_I  in  NBIT  source group 0
FSYNC_FILTER_I  in  NBIT  source group 1
VS_I  in  NBIT  source group 2
AUX_I  in  NBIT  source group 3
CFG_EN_I  in  1  0 = outputs forced low
CFG_MODE_I  in  1  0 = static, 1 = scan
CFG_SEL_I  in  4*(2+IDX_W)  per pin k: {grp[1:0], idx}; pin k field at [k*(2+IDX_W) +: 2+IDX_W], grp in MSBs
CFG_DWELL_I  in  DWELL_W  scan cycles per index; 0 treated as 1
CFG_STRETCH_I  in  STR_W  extra high cycles after a rising edge
CFG_UPDATE_I  in  1  one-cycle strobe; loads all CFG_* into the active set
DEBUG_O  out  4  debug pins
SCAN_IDX_O  out  IDX_W  current scan index
SCAN_WRAP_O  out  1  one-cycle pulse when the scan index wraps to 0
CFG_ERR_O  out  1  active config has an out-of-range idx

Behaviour:
- Reset (priority over everything):
  - all outputs 0.
  - active cfg: en=0, static, sel=0, dwell=0, stretch=0.
  - state IDLE; all counters 0.
- Config:
  - CFG_* inputs are ignored except in the cycle CFG_UPDATE_I=1.
  - On update at edge t: active cfg, state, dwell counter, scan idx, stretch counters and edge history are reloaded or cleared.
  - DEBUG_O reflects the new cfg from edge t+1.
- States: IDLE (en=0), STATIC (en=1, mode=0), SCAN (en=1, mode=1). Transitions occur only on update or reset.
- Pipeline:
  - Stage 1 registers all four source groups.
  - Stage 2 performs select and stretch and registers DEBUG_O.
  - Source change to DEBUG_O latency is 2 cycles.
- Select:
  - STATIC: pin k = group grp_k, bit idx_k.
  - SCAN: pin g = group g, bit scan_idx.
  - IDLE: all pins 0.
- Stretcher (per pin):
  - rise = sel & ~sel_prev.
  - cnt_next = rise ? STRETCH : (cnt ? cnt-1 : 0).
  - out = sel | (cnt != 0).
  - A single-cycle pulse gives exactly STRETCH+1 high cycles.
  - A level held n cycles gives max(n, STRETCH+1) high cycles.
  - A rise during an active stretch reloads the counter.
  - STRETCH=0 is a pure registered passthrough.
- Scan:
  - The dwell counter counts 0..max(DWELL,1)-1. At terminal count, scan_idx increments, wrapping NBIT-1 -> 0.
  - SCAN_WRAP_O is high for exactly the cycle in which SCAN_IDX_O first reads 0 after a wrap. It is not asserted on update-induced returns to 0.
  - On each index change, stretch counters clear and sel_prev loads the newly selected bit, so no spurious edge is detected.
  - Outside SCAN, SCAN_IDX_O = 0 and SCAN_WRAP_O = 0.
- Error handling:
  - An idx >= NBIT in STATIC forces that pin to 0 and sets CFG_ERR_O.
  - CFG_ERR_O holds until an update with all idx in range, or reset.
  - In SCAN, sel idx fields are not checked.
- Simultaneous events:
  - update + dwell terminal: update wins; idx becomes 0, no wrap pulse.
  - reset + update: reset wins.

Decomposition:
- Shared package debug_io_pkg holds:
  - group codes GRP_FSYNC=0, GRP_FILTER=1, GRP_VS=2, GRP_AUX=3.
  - MODE_STATIC / MODE_SCAN.
  - state enum IDLE / STATIC / SCAN.
- One sub-module, debug_pulse_stretch: per-pin edge detect plus counter, instantiated 4x via generate, with inputs sel, clear and stretch.

Test Plan:
1. Hold reset 5 cycles with all sources = 8'hFF. -> DEBUG_O=0, SCAN_IDX_O=0, SCAN_WRAP_O=0, CFG_ERR_O=0 throughout; still 0 after release with no update.
2. STATIC, sel = {FSYNC,0}, {FILTER,0}, {VS,0}, {AUX,0}, stretch=0, update; then drive a=1, b=0, c=1, d=1. -> DEBUG_O=4'b1101 exactly 2 cycles after the input change.
3. STATIC, stretch=3.
   - 1-cycle pulse on VS_I[0] -> DEBUG_O[2] high exactly 4 cycles.
   - Second pulse 2 cycles after the first -> high 6 consecutive cycles.
4. SCAN, dwell=4, all sources = 8'b0000_0101.
   - SCAN_IDX_O steps every 4 cycles 0..7.
   - DEBUG_O=4'b1111 while idx is 0 or 2, else 0.
   - SCAN_WRAP_O pulses once every 32 cycles.
5. SCAN at idx 7, update (en=1, dwell=2) coincident with dwell terminal. -> idx 0, no wrap pulse, next step after 2 cycles.
   - Then update en=0 -> DEBUG_O=0 on the following edge.
6. NBIT=6, STATIC, pin1 idx=7, update. -> DEBUG_O[1]=0 regardless of input, CFG_ERR_O=1; a subsequent valid update clears CFG_ERR_O.
